// File: rtl/axi_dma_copy_master.sv
// Single-channel DMA copy engine with an AXI3-style master port (suffix 0).
// A start command reads one INCR burst of N 64-bit beats from src_addr into
// a 2^LEN_BITS x 64 buffer, then writes the same N beats to dst_addr.
//
// Optional feature macro: DMA_RESP_CHECK_EN
//   defined   : non-zero RRESP0/BRESP0 or an early RLAST0 set the sticky error
//               flag; a read error drains the burst and skips the write phase.
//   undefined : responses are ignored and error stays 0.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, src_addr, dst_addr,
//   num_beats                  command (num_beats 0..2^LEN_BITS)
//   busy, done, error          status (done is a one-cycle pulse)
//   AW*/W*/B*/AR*/R* 0         AXI master channels; all outputs registered
module axi_dma_copy_master #(
    parameter int unsigned ID_BITS   = 4,
    parameter int unsigned LEN_BITS  = 4,
    parameter int unsigned SIZE_BITS = 3,
    parameter int unsigned CMD_ID    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_BITS:0]    num_beats,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ID_BITS-1:0]   AWID0,
    output logic [31:0]          AWADDR0,
    output logic [LEN_BITS-1:0]  AWLEN0,
    output logic [SIZE_BITS-1:0] AWSIZE0,
    output logic                 AWVALID0,
    input  logic                 AWREADY0,
    output logic [ID_BITS-1:0]   WID0,
    output logic [63:0]          WDATA0,
    output logic [7:0]           WSTRB0,
    output logic                 WLAST0,
    output logic                 WVALID0,
    input  logic                 WREADY0,
    input  logic [ID_BITS-1:0]   BID0,
    input  logic [1:0]           BRESP0,
    input  logic                 BVALID0,
    output logic                 BREADY0,
    output logic [ID_BITS-1:0]   ARID0,
    output logic [31:0]          ARADDR0,
    output logic [LEN_BITS-1:0]  ARLEN0,
    output logic [SIZE_BITS-1:0] ARSIZE0,
    output logic                 ARVALID0,
    input  logic                 ARREADY0,
    input  logic [ID_BITS-1:0]   RID0,
    input  logic [63:0]          RDATA0,
    input  logic [1:0]           RRESP0,
    input  logic                 RLAST0,
    input  logic                 RVALID0,
    output logic                 RREADY0
);

    localparam int unsigned DEPTH = 1 << LEN_BITS;
    localparam int unsigned CNT_W = LEN_BITS + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AW   = 3'd3;
    localparam logic [2:0] S_W    = 3'd4;
    localparam logic [2:0] S_B    = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]          state_q, state_d;
    logic [LEN_BITS-1:0] cnt_q, cnt_d;
    logic [LEN_BITS-1:0] last_q, last_d;
    logic [LEN_BITS-1:0] cnt_inc;
    logic [CNT_W-1:0]    n_eff;
    logic [LEN_BITS-1:0] len_cmd;
    logic                rd_beat;
    logic                rd_err;
    logic                wr_err;

    logic                busy_d, done_d, error_d;
    logic [ID_BITS-1:0]  awid_d, wid_d, arid_d;
    logic [31:0]         awaddr_d, araddr_d;
    logic [LEN_BITS-1:0] awlen_d, arlen_d;
    logic [SIZE_BITS-1:0] awsize_d, arsize_d;
    logic                awvalid_d, wvalid_d, wlast_d, bready_d, arvalid_d, rready_d;
    logic [63:0]         wdata_d;
    logic [7:0]          wstrb_d;

    logic [63:0] data_buf [DEPTH];

    // Command beat count, clamped to the buffer depth; burst length is N-1
    assign n_eff   = (num_beats > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_beats;
    assign len_cmd = LEN_BITS'(n_eff - 1'b1);
    assign cnt_inc = cnt_q + 1'b1;
    assign rd_beat = RVALID0 && RREADY0;

`ifdef DMA_RESP_CHECK_EN
    assign rd_err = (RRESP0 != 2'b00) || (RLAST0 && (cnt_q != last_q));
    assign wr_err = (BRESP0 != 2'b00);
`else
    assign rd_err = 1'b0;
    assign wr_err = 1'b0;
`endif

    // Inputs that never steer control (IDs, low address bits, responses when unchecked)
    logic unused_inputs;
    assign unused_inputs = ^{RID0, BID0, RLAST0, RRESP0, BRESP0, src_addr[2:0], dst_addr[2:0]};

    // Read-burst capture into the staging buffer
    always_ff @(posedge clk) begin
        if ((state_q == S_R) && rd_beat) begin
            data_buf[cnt_q] <= RDATA0;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        busy_d    = busy;
        done_d    = 1'b0;
        error_d   = error;
        awid_d    = AWID0;
        wid_d     = WID0;
        arid_d    = ARID0;
        awaddr_d  = AWADDR0;
        araddr_d  = ARADDR0;
        awlen_d   = AWLEN0;
        arlen_d   = ARLEN0;
        awsize_d  = AWSIZE0;
        arsize_d  = ARSIZE0;
        awvalid_d = AWVALID0;
        arvalid_d = ARVALID0;
        wvalid_d  = WVALID0;
        wdata_d   = WDATA0;
        wstrb_d   = WSTRB0;
        wlast_d   = WLAST0;
        bready_d  = BREADY0;
        rready_d  = RREADY0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (num_beats == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_AR;
                        busy_d    = 1'b1;
                        cnt_d     = '0;
                        last_d    = len_cmd;
                        arid_d    = ID_BITS'(CMD_ID);
                        awid_d    = ID_BITS'(CMD_ID);
                        wid_d     = ID_BITS'(CMD_ID);
                        araddr_d  = {src_addr[31:3], 3'b000};
                        awaddr_d  = {dst_addr[31:3], 3'b000};
                        arlen_d   = len_cmd;
                        awlen_d   = len_cmd;
                        arsize_d  = SIZE_BITS'(3);
                        awsize_d  = SIZE_BITS'(3);
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_AR: begin
                if (ARREADY0) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (rd_beat) begin
                    cnt_d   = cnt_inc;
                    error_d = error | rd_err;
                    if (cnt_q == last_q) begin
                        rready_d = 1'b0;
                        cnt_d    = '0;
                        // A failed read still drains the burst but never writes
                        if (error || rd_err) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d   = S_AW;
                            awvalid_d = 1'b1;
                        end
                    end
                end
            end
            S_AW: begin
                if (AWREADY0) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wdata_d   = data_buf[cnt_q];
                    wstrb_d   = 8'hFF;
                    wlast_d   = (last_q == '0);
                    state_d   = S_W;
                end
            end
            S_W: begin
                if (WREADY0) begin
                    if (cnt_q == last_q) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_B;
                    end else begin
                        cnt_d   = cnt_inc;
                        wdata_d = data_buf[cnt_inc];
                        wlast_d = (cnt_inc == last_q);
                    end
                end
            end
            S_B: begin
                if (BVALID0) begin
                    bready_d = 1'b0;
                    error_d  = error | wr_err;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            AWID0    <= '0;
            WID0     <= '0;
            ARID0    <= '0;
            AWADDR0  <= '0;
            ARADDR0  <= '0;
            AWLEN0   <= '0;
            ARLEN0   <= '0;
            AWSIZE0  <= '0;
            ARSIZE0  <= '0;
            AWVALID0 <= 1'b0;
            ARVALID0 <= 1'b0;
            WVALID0  <= 1'b0;
            WDATA0   <= '0;
            WSTRB0   <= '0;
            WLAST0   <= 1'b0;
            BREADY0  <= 1'b0;
            RREADY0  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            busy     <= busy_d;
            done     <= done_d;
            error    <= error_d;
            AWID0    <= awid_d;
            WID0     <= wid_d;
            ARID0    <= arid_d;
            AWADDR0  <= awaddr_d;
            ARADDR0  <= araddr_d;
            AWLEN0   <= awlen_d;
            ARLEN0   <= arlen_d;
            AWSIZE0  <= awsize_d;
            ARSIZE0  <= arsize_d;
            AWVALID0 <= awvalid_d;
            ARVALID0 <= arvalid_d;
            WVALID0  <= wvalid_d;
            WDATA0   <= wdata_d;
            WSTRB0   <= wstrb_d;
            WLAST0   <= wlast_d;
            BREADY0  <= bready_d;
            RREADY0  <= rready_d;
        end
    end

endmodule

// File: tb/tb_axi_dma_copy_master.sv
// Directed testbench for axi_dma_copy_master with a simple reactive AXI slave.
module tb_axi_dma_copy_master;

    localparam int unsigned ID_BITS   = 4;
    localparam int unsigned LEN_BITS  = 4;
    localparam int unsigned SIZE_BITS = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [31:0]          src_addr = '0;
    logic [31:0]          dst_addr = '0;
    logic [LEN_BITS:0]    num_beats = '0;
    logic                 busy, done, error;
    logic [ID_BITS-1:0]   AWID0, WID0, ARID0;
    logic [31:0]          AWADDR0, ARADDR0;
    logic [LEN_BITS-1:0]  AWLEN0, ARLEN0;
    logic [SIZE_BITS-1:0] AWSIZE0, ARSIZE0;
    logic                 AWVALID0, WVALID0, WLAST0, BREADY0, ARVALID0, RREADY0;
    logic [63:0]          WDATA0;
    logic [7:0]           WSTRB0;
    logic                 AWREADY0 = 1'b0;
    logic                 WREADY0 = 1'b0;
    logic [ID_BITS-1:0]   BID0 = '0;
    logic [1:0]           BRESP0 = '0;
    logic                 BVALID0 = 1'b0;
    logic                 ARREADY0 = 1'b0;
    logic [ID_BITS-1:0]   RID0 = '0;
    logic [63:0]          RDATA0 = '0;
    logic [1:0]           RRESP0 = '0;
    logic                 RLAST0 = 1'b0;
    logic                 RVALID0 = 1'b0;

    int checks = 0;
    int errors = 0;

    // Slave knobs
    logic [63:0] rbase = 64'h0;
    int          err_beat = -1;
    bit          wtoggle = 1'b0;
    bit          whold = 1'b0;
    bit          mon_clr = 1'b0;

    // Monitor / slave state
    int          ar_count, aw_count, w_n, b_count, r_beats, done_count;
    int          arv_cycles, awv_cycles, w_early, w_unstable;
    logic [31:0] ar_addr, aw_addr;
    logic [3:0]  ar_len, aw_len;
    logic [63:0] wdata_log [32];
    logic        wlast_log [32];
    int          r_pending = 0;
    int          r_idx = 0;
    bit          b_pending = 1'b0;
    bit          hold_pend = 1'b0;
    logic [63:0] hold_data;

    always #5 clk = ~clk;

    axi_dma_copy_master #(
        .ID_BITS(ID_BITS), .LEN_BITS(LEN_BITS), .SIZE_BITS(SIZE_BITS), .CMD_ID(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .num_beats(num_beats), .busy(busy), .done(done),
        .error(error), .AWID0(AWID0), .AWADDR0(AWADDR0), .AWLEN0(AWLEN0),
        .AWSIZE0(AWSIZE0), .AWVALID0(AWVALID0), .AWREADY0(AWREADY0),
        .WID0(WID0), .WDATA0(WDATA0), .WSTRB0(WSTRB0), .WLAST0(WLAST0),
        .WVALID0(WVALID0), .WREADY0(WREADY0), .BID0(BID0), .BRESP0(BRESP0),
        .BVALID0(BVALID0), .BREADY0(BREADY0), .ARID0(ARID0), .ARADDR0(ARADDR0),
        .ARLEN0(ARLEN0), .ARSIZE0(ARSIZE0), .ARVALID0(ARVALID0),
        .ARREADY0(ARREADY0), .RID0(RID0), .RDATA0(RDATA0), .RRESP0(RRESP0),
        .RLAST0(RLAST0), .RVALID0(RVALID0), .RREADY0(RREADY0)
    );

    // Monitor and slave bookkeeping, sampled on the active edge
    always @(posedge clk) begin
        if (mon_clr) begin
            ar_count = 0; aw_count = 0; w_n = 0; b_count = 0; r_beats = 0;
            done_count = 0; arv_cycles = 0; awv_cycles = 0; w_early = 0;
            w_unstable = 0; ar_addr = '0; aw_addr = '0; ar_len = '0; aw_len = '0;
            hold_pend = 1'b0;
        end else begin
            if (done) done_count++;
            if (ARVALID0) arv_cycles++;
            if (AWVALID0) awv_cycles++;
            if (ARVALID0 && ARREADY0) begin ar_count++; ar_addr = ARADDR0; ar_len = ARLEN0; end
            if (AWVALID0 && AWREADY0) begin aw_count++; aw_addr = AWADDR0; aw_len = AWLEN0; end
            if (WVALID0 && (aw_count == 0)) w_early++;
            if (hold_pend && (!WVALID0 || (WDATA0 !== hold_data))) w_unstable++;
            hold_pend = WVALID0 && !WREADY0;
            hold_data = WDATA0;
            if (WVALID0 && WREADY0) begin
                if (w_n < 32) begin wdata_log[w_n] = WDATA0; wlast_log[w_n] = WLAST0; end
                w_n++;
                if (WLAST0) b_pending = 1'b1;
            end
            if (BVALID0 && BREADY0) begin b_count++; b_pending = 1'b0; end
            if (RVALID0 && RREADY0) r_beats++;
        end
        if (reset || mon_clr) begin
            r_pending = 0; r_idx = 0; b_pending = 1'b0;
        end else begin
            if (ARVALID0 && ARREADY0) begin r_pending = int'(ARLEN0) + 1; r_idx = 0; end
            if (RVALID0 && RREADY0) begin r_idx++; r_pending--; end
        end
    end

    // Slave drive on the falling edge
    always @(negedge clk) begin
        ARREADY0 = 1'b1;
        AWREADY0 = 1'b1;
        RVALID0  = (r_pending > 0);
        RDATA0   = rbase + 64'(r_idx);
        RRESP0   = (RVALID0 && (r_idx == err_beat)) ? 2'd2 : 2'd0;
        RLAST0   = (r_pending == 1);
        BVALID0  = b_pending;
        if (whold)        WREADY0 = 1'b0;
        else if (wtoggle) WREADY0 = ~WREADY0;
        else              WREADY0 = 1'b1;
    end

    task automatic clear_mon();
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int n);
        @(negedge clk);
        src_addr = s; dst_addr = d; num_beats = 5'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic check_wbeats(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (wdata_log[i] !== rbase + 64'(i)) begin
                errors++;
                $display("FAIL %s_wdata[%0d]: got %h expected %h", name, i, wdata_log[i], rbase + 64'(i));
            end
            checks++;
            if (wlast_log[i] !== (i == n - 1)) begin
                errors++;
                $display("FAIL %s_wlast[%0d]: got %b expected %b", name, i, wlast_log[i], (i == n - 1));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_mon();
        repeat (5) @(negedge clk);
        checks++;
        if ({busy, done, error} !== 3'b000) begin
            errors++; $display("FAIL reset_status: got %b expected 000", {busy, done, error});
        end
        checks++;
        if ({ARVALID0, AWVALID0, WVALID0, RREADY0, BREADY0} !== 5'b0) begin
            errors++; $display("FAIL reset_handshake: got %b expected 00000",
                               {ARVALID0, AWVALID0, WVALID0, RREADY0, BREADY0});
        end
        checks++;
        if ({ARADDR0, AWADDR0, WDATA0, WSTRB0, WLAST0, ARLEN0, AWSIZE0} !== '0) begin
            errors++; $display("FAIL reset_fields: got %h expected 0",
                               {ARADDR0, AWADDR0, WDATA0, WSTRB0, WLAST0, ARLEN0, AWSIZE0});
        end
    endtask

    task automatic test_basic_copy();
        clear_mon();
        rbase = 64'hA0; wtoggle = 1'b0;
        pulse_start(32'h1000, 32'h2000, 4);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        checks++;
        if ({ARVALID0, ARADDR0, ARLEN0, ARSIZE0} !== {1'b1, 32'h1000, 4'd3, 3'd3}) begin
            errors++; $display("FAIL basic_ar: got %h expected %h",
                               {ARVALID0, ARADDR0, ARLEN0, ARSIZE0}, {1'b1, 32'h1000, 4'd3, 3'd3});
        end
        wait_done(200, "basic");
        repeat (4) @(negedge clk);
        checks++;
        if ({ar_count, aw_count, b_count, done_count} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
            errors++; $display("FAIL basic_counts: ar %0d aw %0d b %0d done %0d expected 1 each",
                               ar_count, aw_count, b_count, done_count);
        end
        checks++;
        if ({aw_addr, aw_len} !== {32'h2000, 4'd3}) begin
            errors++; $display("FAIL basic_aw: got %h/%0d expected 2000/3", aw_addr, aw_len);
        end
        checks++;
        if (w_n !== 4) begin errors++; $display("FAIL basic_wcount: got %0d expected 4", w_n); end
        checks++;
        if (w_early !== 0) begin errors++; $display("FAIL basic_w_before_aw: got %0d expected 0", w_early); end
        check_wbeats(4, "basic");
        checks++;
        if ({busy, RREADY0, BREADY0, WVALID0} !== 4'b0) begin
            errors++; $display("FAIL basic_idle_after: got %b expected 0000", {busy, RREADY0, BREADY0, WVALID0});
        end
    endtask

    task automatic test_wready_stall();
        clear_mon();
        rbase = 64'hDEAD_BEEF_0000_0100; wtoggle = 1'b1;
        pulse_start(32'h0004_0000, 32'h0005_0000, 16);
        wait_done(400, "stall");
        wtoggle = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ar_len, aw_len} !== {4'd15, 4'd15}) begin
            errors++; $display("FAIL stall_len: got ar %0d aw %0d expected 15", ar_len, aw_len);
        end
        checks++;
        if (w_n !== 16) begin errors++; $display("FAIL stall_wcount: got %0d expected 16", w_n); end
        checks++;
        if (w_unstable !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable expected 0", w_unstable); end
        check_wbeats(16, "stall");
    endtask

    task automatic test_zero_beats();
        clear_mon();
        pulse_start(32'h1000, 32'h2000, 0);
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++; $display("FAIL zero_done: got done %b busy %b expected 1 0", done, busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({arv_cycles, awv_cycles, done_count} !== {32'd0, 32'd0, 32'd1}) begin
            errors++; $display("FAIL zero_bus: arv %0d awv %0d done %0d expected 0 0 1",
                               arv_cycles, awv_cycles, done_count);
        end
    endtask

    task automatic test_unaligned_busy();
        clear_mon();
        rbase = 64'h5500;
        pulse_start(32'h1005, 32'h200F, 2);
        @(negedge clk);
        pulse_start(32'h3000, 32'h4000, 5);
        wait_done(200, "busy");
        repeat (8) @(negedge clk);
        checks++;
        if ({ar_count, done_count, ar_addr, aw_addr} !== {32'd1, 32'd1, 32'h1000, 32'h2008}) begin
            errors++; $display("FAIL busy_ignore: ar %0d done %0d araddr %h awaddr %h expected 1 1 1000 2008",
                               ar_count, done_count, ar_addr, aw_addr);
        end
        check_wbeats(2, "busy");
    endtask

    task automatic test_back_to_back();
        int snap;
        clear_mon();
        rbase = 64'h7700;
        pulse_start(32'h6000, 32'h7000, 1);
        wait_done(100, "b2b_first");
        snap = ar_count;
        // done is high here: this start lands in the DONE cycle and must be ignored
        src_addr = 32'h8000; num_beats = 5'd1; start = 1'b1;
        @(negedge clk);
        src_addr = 32'h9000; dst_addr = 32'hA000; num_beats = 5'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100, "b2b_second");
        repeat (3) @(negedge clk);
        checks++;
        if ({ar_count - snap, ar_addr, aw_addr} !== {32'd1, 32'h9000, 32'hA000}) begin
            errors++; $display("FAIL b2b_accept: new ar %0d araddr %h awaddr %h expected 1 9000 A000",
                               ar_count - snap, ar_addr, aw_addr);
        end
        checks++;
        if (done_count !== 2) begin errors++; $display("FAIL b2b_done: got %0d expected 2", done_count); end
        checks++;
        if ({wlast_log[0], wlast_log[1]} !== 2'b11) begin
            errors++; $display("FAIL b2b_wlast: got %b expected 11", {wlast_log[0], wlast_log[1]});
        end
    endtask

    task automatic test_resp_error();
        clear_mon();
        rbase = 64'hE0; err_beat = 0;
        pulse_start(32'h1000, 32'h2000, 2);
        wait_done(100, "resp");
        err_beat = -1;
        repeat (3) @(negedge clk);
`ifdef DMA_RESP_CHECK_EN
        checks++;
        if ({error, aw_count, awv_cycles, r_beats, done_count} !== {1'b1, 32'd0, 32'd0, 32'd2, 32'd1}) begin
            errors++; $display("FAIL resp_err: error %b aw %0d awv %0d rbeats %0d done %0d expected 1 0 0 2 1",
                               error, aw_count, awv_cycles, r_beats, done_count);
        end
`else
        checks++;
        if ({error, aw_count, w_n, done_count} !== {1'b0, 32'd1, 32'd2, 32'd1}) begin
            errors++; $display("FAIL resp_ignored: error %b aw %0d w %0d done %0d expected 0 1 2 1",
                               error, aw_count, w_n, done_count);
        end
`endif
        pulse_start(32'h1000, 32'h2000, 1);
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL resp_clear: got %b expected 0", error); end
        wait_done(100, "resp_clear");
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_w();
        bit seen = 1'b0;
        clear_mon();
        rbase = 64'hC0; whold = 1'b1;
        pulse_start(32'h1000, 32'h2000, 8);
        for (int i = 0; i < 100; i++) begin
            if (WVALID0) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL midw_reach: WVALID0 got 0 expected 1"); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({WVALID0, AWVALID0, ARVALID0, BREADY0, RREADY0, busy, done} !== 7'b0) begin
            errors++; $display("FAIL midw_drop: got %b expected 0000000",
                               {WVALID0, AWVALID0, ARVALID0, BREADY0, RREADY0, busy, done});
        end
        reset = 1'b0; whold = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if ({done_count, WVALID0, busy} !== {32'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL midw_nodone: done %0d wvalid %b busy %b expected 0 0 0",
                               done_count, WVALID0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_wready_stall();
        test_zero_beats();
        test_unaligned_busy();
        test_back_to_back();
        test_resp_error();
        test_reset_mid_w();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_dma_copy_master.md
Name: axi_dma_copy_master

Overview:
- Single-channel DMA copy engine with an AXI3-style master port (port suffix 0, 64-bit data, 32-bit address).
- On a start command it performs one INCR read burst of N 64-bit beats from a source address into an internal 16×64 buffer.
- It then performs one INCR write burst of the same N beats to a destination address.
- It sits between the DMA register block and the system interconnect or slave memory model.

Parameters:
- ID_BITS, 4, width of all AXI ID fields.
- LEN_BITS, 4, width of AWLEN0/ARLEN0; the maximum burst is 2^LEN_BITS beats.
- SIZE_BITS, 3, width of AWSIZE0/ARSIZE0.
- CMD_ID, 0, constant ID driven on ARID0, AWID0 and WID0.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle command pulse; ignored while busy=1
- src_addr  in  32  source byte address; bits [2:0] forced to 0
- dst_addr  in  32  destination byte address; bits [2:0] forced to 0
- num_beats  in  LEN_BITS+1  beat count, 0..16
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at completion
- error  out  1  sticky error flag; cleared by the next accepted start
- AWID0/AWADDR0/AWLEN0/AWSIZE0/AWVALID0  out  ID_BITS/32/LEN_BITS/SIZE_BITS/1  write address channel
- AWREADY0  in  1
- WID0/WDATA0/WSTRB0/WLAST0/WVALID0  out  ID_BITS/64/8/1/1  write data channel
- WREADY0  in  1
- BID0/BRESP0/BVALID0  in  ID_BITS/2/1  write response channel
- BREADY0  out  1
- ARID0/ARADDR0/ARLEN0/ARSIZE0/ARVALID0  out  ID_BITS/32/LEN_BITS/SIZE_BITS/1  read address channel
- ARREADY0  in  1
- RID0/RDATA0/RRESP0/RLAST0/RVALID0  in  ID_BITS/64/2/1/1  read data channel
- RREADY0  out  1

Behaviour:
- Reset: state IDLE; every output is 0, including busy, done, error, all VALIDs and READYs; the beat counter is 0.
- All outputs are registered.
- States: IDLE, AR, R, AW, W, B, DONE.
- IDLE:
  - start with num_beats=0 → DONE; no bus activity.
  - start with num_beats≥1 → latch addresses and count, then go to AR.
- AR: ARVALID0=1, ARADDR0=src, ARLEN0=N-1, ARSIZE0=3. Hold all fields stable until ARREADY0; the handshake cycle moves the FSM to R.
- R:
  - RREADY0=1; each RVALID0&RREADY0 beat writes RDATA0 into buffer[cnt] and increments cnt.
  - After beat N → AW; RREADY0 drops the following cycle.
- AW: AWVALID0=1, AWADDR0=dst, AWLEN0=N-1, AWSIZE0=3. On AWREADY0 → W. W data is never issued before the AW handshake.
- W:
  - WVALID0=1, WDATA0=buffer[cnt], WSTRB0=8'hFF, WLAST0=1 only on beat N.
  - Data is held stable while WREADY0=0; cnt advances on each handshake.
  - After the last beat → B.
- B: BREADY0=1; on BVALID0 → DONE.
- DONE: done=1 for exactly one cycle, busy=0 from that cycle onward, then IDLE.
- Back-to-back: a start arriving in the DONE cycle is ignored; a start in the following IDLE cycle is accepted.
- RID0, BID0 and RLAST0 are not used for control; beat counting alone ends the R phase.
- Reset asserted mid-transfer aborts immediately: all VALIDs drop, the state returns to IDLE, and done is not pulsed.
- 4KB-boundary crossing is the caller's responsibility and is not checked.

Optional Feature:
- Macro: DMA_RESP_CHECK_EN
- Defined:
  - RRESP0≠0 on any read beat, or BRESP0≠0, sets error.
  - A read error still drains all N read beats, then skips AW/W/B and goes to DONE.
  - RLAST0 asserted on a beat other than N also sets error.
- Undefined: responses are ignored and error stays 0.

Test Plan:
- Reset, then idle 5 cycles → all outputs 0, busy=0.
- start, src=0x1000, dst=0x2000, N=4, slave always ready, RDATA=0xA0..0xA3:
  - ARADDR0=0x1000, ARLEN0=3.
  - AWADDR0=0x2000, AWLEN0=3.
  - W beats A0,A1,A2,A3; WLAST0 on the 4th beat.
  - done pulse once.
- N=16, WREADY0 toggling every other cycle → 16 W beats in order, WDATA0 stable while stalled, AWLEN0=15.
- N=0 → done 1 cycle later, with no ARVALID0/AWVALID0 ever asserted.
- src=0x1005 → ARADDR0=0x1000; start pulsed while busy → ignored, only one AR issued.
- With DMA_RESP_CHECK_EN, RRESP0=2 on beat 1 of N=2 → error=1, no AWVALID0, done pulse.
- Reset mid-W → VALIDs drop next cycle, no done pulse.
